// File: rtl/sha256_padder_if.sv
// Byte-stream input and padded-block output bundle for the SHA-256 padder.
interface sha256_padder_if;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic [15:0]  blk_index;
    logic         blk_ready;
    logic [63:0]  msg_bits;

    // The padder itself.
    modport slave (
        input  in_valid, in_data, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last, blk_index, msg_bits
    );

    // Byte source and block sink.
    modport master (
        output in_valid, in_data, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last, blk_index, msg_bits
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs message bytes into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha256_padder (
    input  logic          clock,
    input  logic          reset,
    sha256_padder_if.slave bus
);
    typedef enum logic [1:0] {FILL, PAD, EMIT, EMIT_PAD} state_t;

    state_t state, state_nxt;

    // Byte i of the block lives at blk_q[63-i], so the packed vector is blk_data directly.
    logic [63:0][7:0] blk_q;
    logic [5:0]       ptr;
    logic [5:0]       last_ptr;
    logic [63:0]      msg_bits_q;
    logic [15:0]      index_q;
    logic             last_q;
    logic             more_q;
    logic             lead_q;
    logic             accept;
    logic             xfer;

    always_ff @(posedge clock) begin
        if (reset) state <= FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        xfer      = 1'b0;
        case (state)
            FILL: begin
                accept = bus.in_valid;
                if (accept) begin
                    if (bus.in_last)       state_nxt = PAD;
                    else if (ptr == 6'd63) state_nxt = EMIT;
                end
            end
            PAD: state_nxt = EMIT;
            EMIT: begin
                xfer = bus.blk_ready;
                if (xfer) state_nxt = more_q ? EMIT_PAD : FILL;
            end
            EMIT_PAD: begin
                xfer = bus.blk_ready;
                if (xfer) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blk_q      <= '0;
            ptr        <= '0;
            last_ptr   <= '0;
            msg_bits_q <= '0;
            index_q    <= '0;
            last_q     <= 1'b0;
            more_q     <= 1'b0;
            lead_q     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        blk_q[6'd63 - ptr] <= bus.in_data;
                        ptr                <= ptr + 6'd1;
                        msg_bits_q         <= msg_bits_q + 64'd8;
                        last_ptr           <= ptr;
                        last_q             <= 1'b0;
                        more_q             <= 1'b0;
                    end
                end
                PAD: begin
                    // Tail past the final byte is already zero from the last clear.
                    if (last_ptr != 6'd63) blk_q[6'd62 - last_ptr] <= 8'h80;
                    if (last_ptr <= 6'd54) begin
                        blk_q[7:0] <= msg_bits_q;
                        last_q     <= 1'b1;
                        more_q     <= 1'b0;
                    end else begin
                        last_q <= 1'b0;
                        more_q <= 1'b1;
                        lead_q <= (last_ptr == 6'd63);
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        blk_q <= '0;
                        ptr   <= '0;
                        if (more_q) begin
                            blk_q[63]  <= lead_q ? 8'h80 : 8'h00;
                            blk_q[7:0] <= msg_bits_q;
                            last_q     <= 1'b1;
                            more_q     <= 1'b0;
                            index_q    <= index_q + 16'd1;
                        end else if (last_q) begin
                            index_q    <= '0;
                            msg_bits_q <= '0;
                            last_q     <= 1'b0;
                        end else begin
                            index_q <= index_q + 16'd1;
                        end
                    end
                end
                EMIT_PAD: begin
                    if (xfer) begin
                        blk_q      <= '0;
                        ptr        <= '0;
                        index_q    <= '0;
                        msg_bits_q <= '0;
                        last_q     <= 1'b0;
                        lead_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.blk_valid = (state == EMIT) || (state == EMIT_PAD);
    assign bus.blk_data  = blk_q;
    assign bus.blk_last  = last_q;
    assign bus.blk_index = index_q;
    assign bus.msg_bits  = msg_bits_q;
endmodule

// File: tb/tb_sha256_padder.sv
// Directed test of sha256_padder with hand-computed padded blocks.
module tb_sha256_padder;
    logic clock;
    logic reset;
    int   n_chk;
    int   n_err;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_fill(input int n, input logic [7:0] v, input logic last_at_end);
        for (int i = 0; i < n; i++) send_byte(v, last_at_end && (i == n - 1));
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!bus.blk_valid && waited < 40) begin
            step();
            waited++;
        end
        if (!bus.blk_valid) chk("blk_valid_timeout", 512'd0, 512'd1);
    endtask

    task automatic get_blk(output logic [511:0] d, output logic l,
                           output logic [15:0] idx, output int waited);
        wait_valid(waited);
        d   = bus.blk_data;
        l   = bus.blk_last;
        idx = bus.blk_index;
        bus.blk_ready = 1'b1;
        step();
        bus.blk_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  512'(bus.in_ready),  512'd1);
        chk({tag, "_blk_valid"}, 512'(bus.blk_valid), 512'd0);
        chk({tag, "_msg_bits"},  512'(bus.msg_bits),  512'd0);
        chk({tag, "_blk_index"}, 512'(bus.blk_index), 512'd0);
    endtask

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

    task automatic run_abc(input string tag);
        logic [511:0] d;
        logic         l;
        logic [15:0]  idx;
        int           w;
        send_abc();
        chk({tag, "_valid_in_pad"}, 512'(bus.blk_valid), 512'd0);
        chk({tag, "_msg_bits"},     512'(bus.msg_bits),  512'd24);
        get_blk(d, l, idx, w);
        chk({tag, "_latency"}, 512'(w),   512'd1);
        chk({tag, "_data"},    d,         ABC_BLK);
        chk({tag, "_last"},    512'(l),   512'd1);
        chk({tag, "_index"},   512'(idx), 512'd0);
        chk_idle({tag, "_after"});
    endtask

    initial begin
        logic [511:0] d;
        logic [511:0] held;
        logic         l;
        logic [15:0]  idx;
        int           w;
        n_chk = 0;
        n_err = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.blk_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_idle("reset");
        chk("reset_blk_data", bus.blk_data, 512'd0);
        chk("reset_blk_last", 512'(bus.blk_last), 512'd0);

        // "abc", and blk_ready while nothing is presented changes nothing
        bus.blk_ready = 1'b1;
        step();
        bus.blk_ready = 1'b0;
        chk_idle("idle_ready");
        run_abc("abc");

        // 55 zero bytes: marker at byte 55, length fits in the same block
        send_fill(55, 8'h00, 1'b1);
        get_blk(d, l, idx, w);
        chk("b55_data",  d, {440'h0, 8'h80, 64'h1B8});
        chk("b55_last",  512'(l), 512'd1);
        chk("b55_index", 512'(idx), 512'd0);

        // 56 zero bytes: marker in block 0, length in block 1
        send_fill(56, 8'h00, 1'b1);
        get_blk(d, l, idx, w);
        chk("b56_0_data",  d, {448'h0, 8'h80, 56'h0});
        chk("b56_0_last",  512'(l), 512'd0);
        chk("b56_0_index", 512'(idx), 512'd0);
        get_blk(d, l, idx, w);
        chk("b56_1_wait",  512'(w), 512'd0);
        chk("b56_1_data",  d, {448'h0, 64'h1C0});
        chk("b56_1_last",  512'(l), 512'd1);
        chk("b56_1_index", 512'(idx), 512'd1);
        chk_idle("b56_after");

        // 64 bytes 0xFF: full block, then marker-led length block
        send_fill(64, 8'hFF, 1'b1);
        get_blk(d, l, idx, w);
        chk("b64_0_data", d, {64{8'hFF}});
        chk("b64_0_last", 512'(l), 512'd0);
        get_blk(d, l, idx, w);
        chk("b64_1_wait",  512'(w), 512'd0);
        chk("b64_1_data",  d, {8'h80, 440'h0, 64'h200});
        chk("b64_1_last",  512'(l), 512'd1);
        chk("b64_1_index", 512'(idx), 512'd1);

        // 70 bytes without a stall in between: second block indexed 1
        send_fill(64, 8'h11, 1'b0);
        get_blk(d, l, idx, w);
        chk("b70_0_data",  d, {64{8'h11}});
        chk("b70_0_last",  512'(l), 512'd0);
        chk("b70_msgbits", 512'(bus.msg_bits), 512'd512);
        send_fill(6, 8'h22, 1'b1);
        get_blk(d, l, idx, w);
        chk("b70_1_data",  d, {{6{8'h22}}, 8'h80, 392'h0, 64'h230});
        chk("b70_1_index", 512'(idx), 512'd1);
        chk("b70_1_last",  512'(l), 512'd1);

        // Stalled output: held stable, input ignored while not ready
        send_abc();
        wait_valid(w);
        held = bus.blk_data;
        chk("stall_data0", held, ABC_BLK);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            step();
            chk("stall_data",     bus.blk_data, held);
            chk("stall_in_ready", 512'(bus.in_ready), 512'd0);
            chk("stall_valid",    512'(bus.blk_valid), 512'd1);
            chk("stall_last",     512'(bus.blk_last), 512'd1);
        end
        bus.in_valid = 1'b0;
        get_blk(d, l, idx, w);
        chk("stall_xfer_wait", 512'(w), 512'd0);
        chk("stall_xfer_data", d, ABC_BLK);
        chk_idle("stall_after");

        // Reset mid-message discards the partial message
        send_fill(10, 8'h5A, 1'b0);
        chk("pre_reset_msg_bits", 512'(bus.msg_bits), 512'd80);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("mid_reset");
        chk("mid_reset_data", bus.blk_data, 512'd0);
        chk("mid_reset_last", 512'(bus.blk_last), 512'd0);
        run_abc("abc2");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
